// File: rtl/hack_soc_pkg.sv
// Shared Hack SoC definitions: default widths and the ROM-loader receiver state encoding.
package hack_soc_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t WAIT_HI = 2'd1;
    localparam state_t WRITE   = 2'd2;
    localparam state_t ACK     = 2'd3;

endpackage

// File: rtl/rom_loader_receiver_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; reset value is selectable per instance.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= {STAGES{RESET_VAL}};
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rom_loader_receiver.sv
// SoC end of the ROM-loader link: turns 4-phase loader words into ROM controller writes
// at auto-incrementing addresses, holding the CPU in reset (loading) while a session runs.
module rom_loader_receiver
    import hack_soc_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_loader_load,
    input  logic                  rom_loader_sck,
    input  logic [DATA_WIDTH-1:0] rom_loader_data,
    output logic                  rom_loader_ack,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_done,
    output logic                  loading,
    output logic [ADDR_WIDTH-1:0] word_count
);

    state_t state, state_next;
    logic   load_sync, sck_sync;
    logic   sck_armed;
    logic   accept;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_load (
        .clk   (clk),
        .reset (reset),
        .d     (rom_loader_load),
        .q     (load_sync)
    );

    // sck resets to 1 so a strobe still high across reset never looks like a fresh rise.
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (rom_loader_sck),
        .q     (sck_sync)
    );

    assign accept = (state == WAIT_HI) && load_sync && sck_sync && sck_armed;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_sync) state_next = WAIT_HI;
            WAIT_HI: begin
                if (!load_sync)  state_next = IDLE;
                else if (accept) state_next = WRITE;
            end
            // The controller write is never aborted; a dropped load just skips the ack.
            WRITE:   if (mem_wr_done) state_next = load_sync ? ACK : IDLE;
            ACK: begin
                if (!load_sync)     state_next = IDLE;
                else if (!sck_sync) state_next = WAIT_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_wr_req     = (state == WRITE);
        rom_loader_ack = (state == ACK);
        loading        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_addr <= '0;
            word_count  <= '0;
            mem_wr_data <= '0;
            sck_armed   <= 1'b0;
        end else begin
            if (!sck_sync) sck_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (load_sync) begin
                        mem_wr_addr <= '0;
                        word_count  <= '0;
                    end
                end
                WAIT_HI: begin
                    if (accept) begin
                        mem_wr_data <= rom_loader_data;
                        sck_armed   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_wr_done) begin
                        mem_wr_addr <= mem_wr_addr + 1'b1;
                        word_count  <= word_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader_receiver.sv
// Bench for rom_loader_receiver: a 16-bit-address and a 2-bit-address instance run in lockstep
// from one loader model; a scoreboard checks every write the controller sees.
module tb_rom_loader_receiver;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int AWS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic          sck = 1'b0;
    logic [DW-1:0] data = '0;
    logic          resp_done = 1'b0;
    logic          spur_done = 1'b0;
    logic          done;

    logic           ack_m, req_m, loading_m;
    logic [AW-1:0]  addr_m, count_m;
    logic [DW-1:0]  wdata_m;
    logic           ack_s, req_s, loading_s;
    logic [AWS-1:0] addr_s, count_s;
    logic [DW-1:0]  wdata_s;

    assign done = resp_done | spur_done;

    always #5 clk = ~clk;

    rom_loader_receiver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .rom_loader_load (load),
        .rom_loader_sck  (sck),
        .rom_loader_data (data),
        .rom_loader_ack  (ack_m),
        .mem_wr_req      (req_m),
        .mem_wr_addr     (addr_m),
        .mem_wr_data     (wdata_m),
        .mem_wr_done     (done),
        .loading         (loading_m),
        .word_count      (count_m)
    );

    rom_loader_receiver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWS), .SYNC_STAGES(2)) dut_small (
        .clk             (clk),
        .reset           (reset),
        .rom_loader_load (load),
        .rom_loader_sck  (sck),
        .rom_loader_data (data),
        .rom_loader_ack  (ack_s),
        .mem_wr_req      (req_s),
        .mem_wr_addr     (addr_s),
        .mem_wr_data     (wdata_s),
        .mem_wr_done     (done),
        .loading         (loading_s),
        .word_count      (count_s)
    );

    typedef struct {
        logic [AW-1:0]  a;
        logic [AWS-1:0] as;
        logic [DW-1:0]  d;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            done_delay = 0;
    logic          expect_ack = 1'b1;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ROM controller model: completes each request after done_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (req_m && !reset) begin
                for (int i = 0; i < done_delay; i++) begin
                    check("ack_low_while_pending", 32'(ack_m), 32'd0);
                    @(negedge clk);
                end
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                check("ack_after_done", 32'(ack_m), 32'(expect_ack));
                check("req_drop_after_done", 32'(req_m), 32'd0);
            end
        end
    end

    // Scoreboard monitor: pops on each new request, checks addr/data held while req is high.
    initial begin
        logic prev_req;
        exp_t cur;
        prev_req = 1'b0;
        cur = '{'0, '0, '0};
        forever begin
            @(negedge clk);
            if (req_m && !prev_req) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", addr_m, wdata_m);
                end else begin
                    cur = sb.pop_front();
                end
            end
            if (req_m) begin
                check("wr_addr", 32'(addr_m), 32'(cur.a));
                check("wr_data", 32'(wdata_m), 32'(cur.d));
                check("wr_addr_small", 32'(addr_s), 32'(cur.as));
                check("wr_data_small", 32'(wdata_s), 32'(cur.d));
                check("req_small", 32'(req_s), 32'd1);
            end
            prev_req = req_m;
        end
    end

    task automatic push_exp(input logic [DW-1:0] w);
        sb.push_back('{exp_addr, exp_addr[AWS-1:0], w});
        exp_addr++;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n;
        n = 0;
        while (ack_m !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ack_m), 32'(v));
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        push_exp(w);
        data = w;
        sck  = 1'b1;
        repeat (2) @(negedge clk);
        check("req_not_early", 32'(req_m), 32'd0);
        @(negedge clk);
        check("req_latency", 32'(req_m), 32'd1);
        wait_ack(1'b1, "ack_rise");
        sck = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic start_session();
        load     = 1'b1;
        exp_addr = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_session();
        load = 1'b0;
        repeat (2) @(negedge clk);
        check("loading_held", 32'(loading_m), 32'd1);
        @(negedge clk);
        check("loading_fall", 32'(loading_m), 32'd0);
        check("loading_fall_small", 32'(loading_s), 32'd0);
    endtask

    initial begin
        int n;
        repeat (4) @(negedge clk);
        check("rst_ack", 32'(ack_m), 32'd0);
        check("rst_req", 32'(req_m), 32'd0);
        check("rst_loading", 32'(loading_m), 32'd0);
        check("rst_addr", 32'(addr_m), 32'd0);
        check("rst_data", 32'(wdata_m), 32'd0);
        check("rst_count", 32'(count_m), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Three-word session
        start_session();
        send_word(16'h0002);
        send_word(16'hEC10);
        send_word(16'h0000);
        check("count_s1", 32'(count_m), 32'd3);
        check("count_s1_small", 32'(count_s), 32'd3);
        end_session();

        // Second session: stray done ignored, addresses restart, slow controller
        start_session();
        check("count_cleared", 32'(count_m), 32'd0);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_done_ack", 32'(ack_m), 32'd0);
        check("spur_done_req", 32'(req_m), 32'd0);
        check("spur_done_count", 32'(count_m), 32'd0);
        send_word(16'h1234);
        check("count_restart", 32'(count_m), 32'd1);
        done_delay = 20;
        send_word(16'hBEEF);
        done_delay = 0;
        check("count_slow", 32'(count_m), 32'd2);

        // load drops while the write is outstanding
        done_delay = 10;
        expect_ack = 1'b0;
        push_exp(16'h5A5A);
        data = 16'h5A5A;
        sck  = 1'b1;
        repeat (4) @(negedge clk);
        load = 1'b0;
        n = 0;
        while (req_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drop_write_finished", 32'(req_m), 32'd0);
        repeat (2) @(negedge clk);
        check("drop_no_ack", 32'(ack_m), 32'd0);
        check("drop_loading", 32'(loading_m), 32'd0);
        check("drop_count", 32'(count_m), 32'd3);
        sck = 1'b0;
        repeat (5) @(negedge clk);
        check("drop_still_no_ack", 32'(ack_m), 32'd0);
        expect_ack = 1'b1;
        done_delay = 0;

        // Five words: the 2-bit instance wraps its address and count
        start_session();
        for (int i = 0; i < 5; i++) send_word(16'h1000 + 16'(i));
        check("count_5", 32'(count_m), 32'd5);
        check("count_wrap_small", 32'(count_s), 32'd1);
        check("addr_wrap_small", 32'(addr_s), 32'd1);
        end_session();

        // Reset while in ACK with sck still high
        start_session();
        push_exp(16'hABCD);
        data = 16'hABCD;
        sck  = 1'b1;
        wait_ack(1'b1, "ack_rise_pre_reset");
        reset = 1'b1;
        @(negedge clk);
        check("rst_ack_ack", 32'(ack_m), 32'd0);
        check("rst_ack_loading", 32'(loading_m), 32'd0);
        check("rst_ack_addr", 32'(addr_m), 32'd0);
        check("rst_ack_count", 32'(count_m), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("sck_high_no_req", 32'(req_m), 32'd0);
        check("sck_high_no_count", 32'(count_m), 32'd0);
        check("sck_high_loading", 32'(loading_m), 32'd1);
        sck = 1'b0;
        repeat (5) @(negedge clk);
        exp_addr = '0;
        send_word(16'h7777);
        check("count_after_reset", 32'(count_m), 32'd1);
        end_session();

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
